muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports and upstream of its write port. It takes the two source operands read from the register file, computes one RV32M result over multiple cycles, and drives the register-file write port (`ad3`/`we3`/`wd3`) for exactly one cycle when the result is ready. It uses one shift/add-subtract step per cycle and has a fast path for the architecturally defined divide special cases.

---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// One shift-add (multiply) or restoring-division step per cycle, plus a fast
// path for divide-by-zero and signed-overflow results.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, op            request (sampled in IDLE) and RV32M funct3
//   src_a, src_b         rs1 / rs2 operand values
//   rd_addr              destination register
//   busy, done           unit occupied / one-cycle result-valid pulse
//   ad3, we3, wd3        register-file write port (address, enable, data)
module muldiv_unit #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic [DATA_WIDTH-1:0]    src_a,
   input  logic [DATA_WIDTH-1:0]    src_b,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] ad3,
   output logic                     we3,
   output logic [DATA_WIDTH-1:0]    wd3
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned W2 = 2 * DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                   state_q, state_n;
   logic [2:0]               op_q;
   logic [ADDRESS_WIDTH-1:0] rd_q;
   logic [W-1:0]             opnd_q;   // multiplicand or divisor magnitude
   logic [W2-1:0]            acc_q;    // {product} or {remainder, quotient}
   logic                     neg_q;    // negate the final result
   logic                     spec_q;   // acc_q low half already holds the result
   logic [CW-1:0]            cnt_q;

   logic                     busy_d, done_d, we3_d;
   logic [ADDRESS_WIDTH-1:0] ad3_d;
   logic [W-1:0]             wd3_d;

   // Operand conditioning for a new request
   logic         sign_a, sign_b, abs_sel_a, abs_sel_b, neg_d;
   logic         div_zero, div_ovf, special;
   logic [W-1:0] opa, opb, spec_res;

   assign sign_a = src_a[W-1];
   assign sign_b = src_b[W-1];

   always_comb begin
      abs_sel_a = 1'b0;
      abs_sel_b = 1'b0;
      neg_d     = 1'b0;
      case (op)
         3'b001:  begin abs_sel_a = 1'b1; abs_sel_b = 1'b1; neg_d = sign_a ^ sign_b; end
         3'b010:  begin abs_sel_a = 1'b1; neg_d = sign_a; end
         3'b100:  begin abs_sel_a = 1'b1; abs_sel_b = 1'b1; neg_d = sign_a ^ sign_b; end
         3'b110:  begin abs_sel_a = 1'b1; abs_sel_b = 1'b1; neg_d = sign_a; end
         default: ;
      endcase
   end

   assign opa = (abs_sel_a && sign_a) ? (~src_a + W'(1)) : src_a;
   assign opb = (abs_sel_b && sign_b) ? (~src_b + W'(1)) : src_b;

   // Architecturally defined divide results that bypass iteration
   assign div_zero = (src_b == '0);
   assign div_ovf  = (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1) && !op[0];
   assign special  = op[2] && (div_zero || div_ovf);

   always_comb begin
      spec_res = '0;
      if (div_zero)
         spec_res = op[1] ? src_a : '1;
      else if (div_ovf)
         spec_res = op[1] ? '0 : src_a;
   end

   // One iteration step
   logic [W:0]    mul_sum, rem_sh, div_diff;
   logic [W2-1:0] mul_next, div_next, acc_step, prod_fix;
   logic [W-1:0]  div_raw, div_fix, result_c;

   assign mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[W-1:1]};

   assign rem_sh   = {acc_q[W2-1:W], acc_q[W-1]};
   assign div_diff = rem_sh - {1'b0, opnd_q};
   assign div_next = div_diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

   assign acc_step = op_q[2] ? div_next : mul_next;

   // Sign correction applies to the full product so the high half is right
   assign prod_fix = neg_q ? (~acc_step + W2'(1)) : acc_step;
   assign div_raw  = op_q[1] ? acc_step[W2-1:W] : acc_step[W-1:0];
   assign div_fix  = neg_q ? (~div_raw + W'(1)) : div_raw;

   always_comb begin
      if (spec_q)
         result_c = acc_q[W-1:0];
      else if (op_q[2])
         result_c = div_fix;
      else if (op_q[1:0] == 2'b00)
         result_c = prod_fix[W-1:0];
      else
         result_c = prod_fix[W2-1:W];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_n;
   end

   // Next state; special results spend one cycle in CALC so the write lines up
   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (start) state_n = S_CALC;
         S_CALC:  if (spec_q || (cnt_q == CW'(W-1))) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      busy_d = (state_n != S_IDLE);
      done_d = (state_n == S_DONE) && (state_q == S_CALC);
      we3_d  = done_d && (rd_q != '0);
      ad3_d  = done_d ? rd_q : ad3;
      wd3_d  = done_d ? result_c : wd3;
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         we3  <= 1'b0;
         ad3  <= '0;
         wd3  <= '0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         we3  <= we3_d;
         ad3  <= ad3_d;
         wd3  <= wd3_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= '0;
         rd_q   <= '0;
         opnd_q <= '0;
         acc_q  <= '0;
         neg_q  <= 1'b0;
         spec_q <= 1'b0;
         cnt_q  <= '0;
      end else if (state_q == S_IDLE) begin
         if (start) begin
            op_q  <= op;
            rd_q  <= rd_addr;
            cnt_q <= '0;
            if (special) begin
               spec_q <= 1'b1;
               neg_q  <= 1'b0;
               acc_q  <= {{W{1'b0}}, spec_res};
            end else begin
               spec_q <= 1'b0;
               neg_q  <= neg_d;
               opnd_q <= op[2] ? opb : opa;
               acc_q  <= {{W{1'b0}}, (op[2] ? opa : opb)};
            end
         end
      end else if (state_q == S_CALC) begin
         acc_q <= acc_step;
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, special divide
// results, x0 suppression, ignored start while busy, async reset, and random ops.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic [4:0]  rd_addr;
   logic        busy, done, we3;
   logic [4:0]  ad3;
   logic [31:0] wd3;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .ad3     (ad3),
      .we3     (we3),
      .wd3     (wd3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference results straight from the RV32M definitions using 64-bit arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      r  = '0;
      p  = '0;
      case (o)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Issue one operation, then check latency, write port and return to idle
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit inject);
      logic [31:0] exp;
      bit          spec, got;
      int          lat, lat_exp;
      exp     = ref_res(o, a, b);
      spec    = o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat_exp = spec ? 1 : 32;
      got     = 0;
      lat     = 0;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b; rd_addr = rd;
      @(posedge clk); #1;
      start = 1'b0;
      // scramble inputs so the result must come from latched state
      op = 3'($urandom_range(0, 7)); src_a = $urandom; src_b = $urandom;
      rd_addr = 5'($urandom_range(0, 31));
      check("busy_after_accept", busy, 1);
      for (int n = 1; n <= 40 && !got; n++) begin
         @(posedge clk); #1;
         if (inject && n == 5) start = 1'b1;
         if (inject && n == 6) start = 1'b0;
         if (done) begin
            got = 1;
            lat = n;
         end
      end
      check("done_seen", got, 1);
      if (got) begin
         check("latency", lat, lat_exp);
         check("we3", we3, (rd != 0));
         check("ad3", ad3, rd);
         check("wd3", wd3, exp);
         @(posedge clk); #1;
         check("done_drop", done, 0);
         check("we3_drop", we3, 0);
         check("busy_drop", busy, 0);
         check("ad3_hold", ad3, rd);
         check("wd3_hold", wd3, exp);
      end
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      logic [4:0]  rrd;
      int          sel;

      rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; rd_addr = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we3", we3, 0);
      check("rst_ad3", ad3, 0);
      check("rst_wd3", wd3, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed multiply / divide cases
      run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd1,         5'd9,  0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 0);
      run_op(3'd5, 32'd100,       32'd7,         5'd12, 0);
      run_op(3'd7, 32'd100,       32'd7,         5'd13, 0);
      run_op(3'd4, 32'd3,         32'hFFFF_FFFF, 5'd14, 0);

      // Special divide results
      run_op(3'd5, 32'hDEAD_BEEF, 32'd0,         5'd15, 0);
      run_op(3'd6, 32'h0000_1234, 32'd0,         5'd16, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 0);
      run_op(3'd7, 32'h0000_00AB, 32'd0,         5'd19, 0);
      run_op(3'd4, 32'h0000_0055, 32'd0,         5'd20, 0);

      // Write to x0 suppressed; start while busy ignored
      run_op(3'd0, 32'd1234,      32'd5678,      5'd0,  0);
      run_op(3'd0, 32'h0001_0003, 32'h0002_0007, 5'd21, 1);

      // Asynchronous reset mid-operation
      @(negedge clk);
      start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9; rd_addr = 5'd22;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_we3", we3, 0);
      check("arst_ad3", ad3, 0);
      check("arst_wd3", wd3, 0);
      repeat (3) begin
         @(posedge clk); #1;
         check("arst_hold_we3", we3, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 35; n++) begin
         @(posedge clk); #1;
         check("post_rst_no_write", we3, 0);
      end
      run_op(3'd2, 32'h8765_4321, 32'h1234_5678, 5'd23, 0);

      // Randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         ro  = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         rrd = 5'($urandom_range(0, 31));
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) rb = 32'($urandom_range(1, 15));
         else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         run_op(ro, ra, rb, rrd, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
